tdm_demux_4: RTL and testbench
==============================

Name: tdm_demux_4

Overview:
Receive-side counterpart of the 4:1 channel multiplexer. Takes a time-division-multiplexed stream of 4 slots per frame, marked by a frame-sync flag on slot 0. Locks to the frame, steers each slot to its own channel, and presents all four channels together, held stable, once per complete frame. Sits after the channel mux / link, feeding per-channel consumers.

Parameters:
WIDTH, 1, data bits per slot (bench also runs 8)
SYNC_LOSS_LIMIT, 3, consecutive missing slot-0 syncs before dropping lock (range 1..7)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a slot beat is present this cycle
in_data  input  WIDTH  slot payload
in_sync  input  1  qualifies a beat as slot 0 (frame start); ignored when in_valid=0
out0  output  WIDTH  channel 0 (slot 0), held between frames
out1  output  WIDTH  channel 1 (slot 1), held
out2  output  WIDTH  channel 2 (slot 2), held
out3  output  WIDTH  channel 3 (slot 3), held
out_valid  output  1  one-cycle pulse when out0..out3 update
locked  output  1  frame alignment established
slot  output  2  slot index expected for the next beat (0 while HUNT)
sync_err  output  1  one-cycle pulse on any sync violation

Behaviour:
- Reset (async assert, sync release): out0..out3=0, out_valid=0, locked=0, slot=0, sync_err=0, state=HUNT, miss count=0, shadow regs=0.
- A beat is a cycle with in_valid=1. Cycles with in_valid=0 change no state. Gaps of any length are allowed anywhere in a frame.
- State HUNT: beats without in_sync are discarded, with no sync_err. A beat with in_sync: shadow[0]<=in_data, slot<=1, state<=LOCKED, locked=1 from the next cycle.
- State LOCKED, beat at slot s:
  - s=1..3, in_sync=0: shadow[s]<=in_data, slot<=s+1 (mod 4).
  - s=1..3, in_sync=1 (early sync): realign. The partial frame is discarded, with no out_valid. The beat becomes slot 0: shadow[0]<=in_data, slot<=1. sync_err pulses. Miss count is unchanged.
  - s=0, in_sync=1: shadow[0]<=in_data, slot<=1, miss count<=0.
  - s=0, in_sync=0 (missing sync): sync_err pulses and miss count increments.
    - If the new count is below SYNC_LOSS_LIMIT: flywheel. The beat is accepted as slot 0.
    - If the new count equals SYNC_LOSS_LIMIT: the beat is discarded, state<=HUNT, locked<=0, slot<=0, miss count<=0.
- Frame completion: on the beat accepted at s=3, on the next rising edge out0..out2<=shadow[0..2], out3<=in_data, and out_valid=1 for exactly that cycle. Latency from the slot-3 beat to new outputs is 1 cycle. Outputs hold otherwise, including during HUNT and after lock loss.
- A sync beat arriving the cycle right after slot 3 is normal slot 0 (back-to-back frames). Throughput is one beat per cycle with no stall.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is lost.
- No back-pressure. The block always accepts beats.

Decomposition:
- Shared package tdm_pkg:
  - NCH=4, SLOT_W=2.
  - State enum {HUNT, LOCKED}.
  - Miss-count width MISS_W=3.
- One sub-module, tdm_sync_tracker: the HUNT/LOCKED FSM, slot counter and miss counter.
  - Inputs: in_valid, in_sync.
  - Outputs: slot, locked, accept, frame_done, sync_err.
- The top level holds the shadow and output registers.

Test Plan (WIDTH=8, SYNC_LOSS_LIMIT=3):
1. Reset, then beats (sync)0x11,0x22,0x33,0x44 -> cycle after 0x44: out0..3=0x11,0x22,0x33,0x44, out_valid pulse of 1 cycle, locked=1, sync_err never set.
2. Leading beats 0xAA,0xBB without sync, then frame 0x01..0x04 with in_valid gaps of 0/2/5 cycles between beats -> outputs 0x01..0x04, exactly one out_valid, no sync_err during HUNT.
3. Locked; frame 0x10,0x20 then early (sync)0x50,0x60,0x70,0x80 -> one sync_err pulse at 0x50, no out_valid for the partial frame, outputs 0x50,0x60,0x70,0x80.
4. Locked; 3 consecutive frames with no in_sync on slot 0 -> sync_err on each; frames 1–2 output normally, at the 3rd slot-0 beat locked=0, outputs keep frame-2 values, next sync relocks.
5. Back-to-back frames A0..A3,B0..B3 with no gaps -> out_valid pulses exactly 4 cycles apart, with correct values each time.
6. Assert rst_n=0 after slot 2 of a locked frame -> all outputs 0, locked=0 immediately; after release a full frame is needed before out_valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants for the 4-slot TDM receive path: channel count, slot/miss widths and
// frame-tracker state encodings.
package tdm_pkg;

  localparam int unsigned NCH    = 4;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned MISS_W = 3;

  typedef logic [0:0] state_t;

  localparam state_t HUNT   = 1'b0;
  localparam state_t LOCKED = 1'b1;

endpackage

// File: rtl/tdm_sync_tracker.sv
// Frame alignment tracker: HUNT/LOCKED FSM, expected-slot counter and missing-sync counter.
// Tells the datapath which beats to keep and when a frame completes.
module tdm_sync_tracker
  import tdm_pkg::*;
#(
  parameter int unsigned SYNC_LOSS_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sync,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              accept,
  output logic              frame_done,
  output logic              sync_err
);

  localparam logic [MISS_W-1:0] LossLimit = MISS_W'(SYNC_LOSS_LIMIT);

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [MISS_W-1:0]   miss_inc;
  logic                sync_err_q, sync_err_d;

  assign miss_inc = miss_q + MISS_W'(1);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    miss_d     = miss_q;
    sync_err_d = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    if (in_valid) begin
      if (state_q == HUNT) begin
        if (in_sync) begin
          accept  = 1'b1;
          state_d = LOCKED;
          slot_d  = SLOT_W'(1);
        end
      end else if (in_sync) begin
        // Sync always restarts the frame; mid-frame it is an early-sync realign.
        accept = 1'b1;
        slot_d = SLOT_W'(1);
        if (slot_q == '0) begin
          miss_d = '0;
        end else begin
          sync_err_d = 1'b1;
        end
      end else if (slot_q != '0) begin
        accept     = 1'b1;
        slot_d     = slot_q + SLOT_W'(1);
        frame_done = (slot_q == SLOT_W'(NCH - 1));
      end else begin
        sync_err_d = 1'b1;
        if (miss_inc == LossLimit) begin
          state_d = HUNT;
          slot_d  = '0;
          miss_d  = '0;
        end else begin
          // Flywheel: trust the slot count and take the beat as slot 0.
          miss_d = miss_inc;
          accept = 1'b1;
          slot_d = SLOT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      miss_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      miss_q     <= miss_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign slot     = slot_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = sync_err_q;

endmodule

// File: rtl/tdm_demux_4.sv
// 4-slot TDM demultiplexer: collects slots 0..2 in shadow registers and publishes all four
// channels together, held stable, one cycle after the slot-3 beat.
module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_LOSS_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_sync,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic              out_valid,
  output logic              locked,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err
);

  logic              accept;
  logic              frame_done;
  logic [SLOT_W-1:0] wr_idx;

  logic [WIDTH-1:0]  shadow0_q, shadow1_q, shadow2_q;
  logic [WIDTH-1:0]  out0_q, out1_q, out2_q, out3_q;
  logic              out_valid_q;

  tdm_sync_tracker #(
    .SYNC_LOSS_LIMIT(SYNC_LOSS_LIMIT)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .slot      (slot),
    .locked    (locked),
    .accept    (accept),
    .frame_done(frame_done),
    .sync_err  (sync_err)
  );

  // Any accepted sync beat lands in slot 0, even when it arrives early.
  assign wr_idx = in_sync ? '0 : slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow0_q <= '0;
      shadow1_q <= '0;
      shadow2_q <= '0;
    end else if (accept) begin
      case (wr_idx)
        2'd0:    shadow0_q <= in_data;
        2'd1:    shadow1_q <= in_data;
        2'd2:    shadow2_q <= in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= frame_done;
      if (frame_done) begin
        out0_q <= shadow0_q;
        out1_q <= shadow1_q;
        out2_q <= shadow2_q;
        out3_q <= in_data;
      end
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4 (WIDTH=8, SYNC_LOSS_LIMIT=3): a per-cycle vector table plus
// hand-written sequences for gapped frames and mid-frame reset.
module tb_tdm_demux_4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sync = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] out0, out1, out2, out3;
  logic         out_valid, locked, sync_err;
  logic [1:0]   slot;
  logic [31:0]  outs;

  assign outs = {out0, out1, out2, out3};

  tdm_demux_4 #(
    .WIDTH          (W),
    .SYNC_LOSS_LIMIT(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sync  (in_sync),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out_valid(out_valid),
    .locked   (locked),
    .slot     (slot),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        e_ov;
    logic        e_lk;
    logic [1:0]  e_slot;
    logic        e_err;
    logic [31:0] e_out;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ov_count = 0;
  int   err_count = 0;

  always @(negedge clk) begin
    if (out_valid) ov_count++;
    if (sync_err) err_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after the following posedge.
  task automatic cycle(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic add(input logic v, input logic s, input logic [7:0] d, input logic ov,
                     input logic lk, input logic [1:0] sl, input logic err,
                     input logic [31:0] o);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.e_ov = ov; t.e_lk = lk; t.e_slot = sl; t.e_err = err;
    t.e_out = o;
    vq.push_back(t);
  endtask

  task automatic check_state(input string tag, input logic ov, input logic lk,
                             input logic [1:0] sl, input logic err, input logic [31:0] o);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".slot"}, 32'(slot), 32'(sl));
    check({tag, ".sync_err"}, 32'(sync_err), 32'(err));
    check({tag, ".outs"}, outs, o);
  endtask

  int ov0, err0;

  initial begin
    // Basic frame, then back-to-back frames A and B, one idle cycle.
    add(1, 1, 8'h11, 0, 1, 1, 0, 32'h0);
    add(1, 0, 8'h22, 0, 1, 2, 0, 32'h0);
    add(1, 0, 8'h33, 0, 1, 3, 0, 32'h0);
    add(1, 0, 8'h44, 1, 1, 0, 0, 32'h11223344);
    add(1, 1, 8'hA0, 0, 1, 1, 0, 32'h11223344);
    add(1, 0, 8'hA1, 0, 1, 2, 0, 32'h11223344);
    add(1, 0, 8'hA2, 0, 1, 3, 0, 32'h11223344);
    add(1, 0, 8'hA3, 1, 1, 0, 0, 32'hA0A1A2A3);
    add(1, 1, 8'hB0, 0, 1, 1, 0, 32'hA0A1A2A3);
    add(1, 0, 8'hB1, 0, 1, 2, 0, 32'hA0A1A2A3);
    add(1, 0, 8'hB2, 0, 1, 3, 0, 32'hA0A1A2A3);
    add(1, 0, 8'hB3, 1, 1, 0, 0, 32'hB0B1B2B3);
    add(0, 0, 8'hFF, 0, 1, 0, 0, 32'hB0B1B2B3);
    // Early sync at slot 2 realigns.
    add(1, 1, 8'h10, 0, 1, 1, 0, 32'hB0B1B2B3);
    add(1, 0, 8'h20, 0, 1, 2, 0, 32'hB0B1B2B3);
    add(1, 1, 8'h50, 0, 1, 1, 1, 32'hB0B1B2B3);
    add(1, 0, 8'h60, 0, 1, 2, 0, 32'hB0B1B2B3);
    add(1, 0, 8'h70, 0, 1, 3, 0, 32'hB0B1B2B3);
    add(1, 0, 8'h80, 1, 1, 0, 0, 32'h50607080);
    // Three frames without sync: two flywheel, third drops lock.
    add(1, 0, 8'hC0, 0, 1, 1, 1, 32'h50607080);
    add(1, 0, 8'hC1, 0, 1, 2, 0, 32'h50607080);
    add(1, 0, 8'hC2, 0, 1, 3, 0, 32'h50607080);
    add(1, 0, 8'hC3, 1, 1, 0, 0, 32'hC0C1C2C3);
    add(1, 0, 8'hD0, 0, 1, 1, 1, 32'hC0C1C2C3);
    add(1, 0, 8'hD1, 0, 1, 2, 0, 32'hC0C1C2C3);
    add(1, 0, 8'hD2, 0, 1, 3, 0, 32'hC0C1C2C3);
    add(1, 0, 8'hD3, 1, 1, 0, 0, 32'hD0D1D2D3);
    add(1, 0, 8'hE0, 0, 0, 0, 1, 32'hD0D1D2D3);
    add(1, 0, 8'hE1, 0, 0, 0, 0, 32'hD0D1D2D3);
    add(1, 0, 8'hE2, 0, 0, 0, 0, 32'hD0D1D2D3);
    add(1, 0, 8'hE3, 0, 0, 0, 0, 32'hD0D1D2D3);
    add(1, 1, 8'hF0, 0, 1, 1, 0, 32'hD0D1D2D3);
    add(1, 0, 8'hF1, 0, 1, 2, 0, 32'hD0D1D2D3);
    add(1, 0, 8'hF2, 0, 1, 3, 0, 32'hD0D1D2D3);
    add(1, 0, 8'hF3, 1, 1, 0, 0, 32'hF0F1F2F3);

    rst_n = 1'b0;
    #1;
    check_state("reset", 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      cycle(vq[i].v, vq[i].s, vq[i].d);
      check_state($sformatf("vec%0d", i), vq[i].e_ov, vq[i].e_lk, vq[i].e_slot, vq[i].e_err,
                  vq[i].e_out);
    end

    // Fresh reset, then unsynced beats in HUNT followed by a gapped frame.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_state("reset2", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ov0  = ov_count;
    err0 = err_count;
    cycle(1, 0, 8'hAA);
    cycle(1, 0, 8'hBB);
    check("hunt.locked", 32'(locked), 32'h0);
    check("hunt.sync_err_count", 32'(err_count - err0), 32'h0);
    cycle(1, 1, 8'h01);
    cycle(1, 0, 8'h02);
    repeat (2) cycle(0, 0, 8'h00);
    cycle(1, 0, 8'h03);
    check("gap.slot", 32'(slot), 32'h3);
    repeat (5) cycle(0, 1, 8'h99);
    check("gap.slot_hold", 32'(slot), 32'h3);
    cycle(1, 0, 8'h04);
    check_state("gap.done", 1, 1, 0, 0, 32'h01020304);
    cycle(0, 0, 8'h00);
    check("gap.ov_count", 32'(ov_count - ov0), 32'h1);
    check("gap.err_count", 32'(err_count - err0), 32'h0);

    // Reset after slot 2 of a locked frame.
    cycle(1, 1, 8'h31);
    cycle(1, 0, 8'h32);
    cycle(1, 0, 8'h33);
    check("mid.slot", 32'(slot), 32'h3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_state("mid.reset", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ov0 = ov_count;
    cycle(1, 0, 8'h34);
    check("post.locked", 32'(locked), 32'h0);
    cycle(1, 1, 8'h51);
    cycle(1, 0, 8'h52);
    cycle(1, 0, 8'h53);
    check("post.no_ov", 32'(ov_count - ov0), 32'h0);
    cycle(1, 0, 8'h54);
    check_state("post.done", 1, 1, 0, 0, 32'h51525354);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
